// File: rtl/bus_decoder.sv
// bus_decoder: address decoder / wait-state generator between a simple CPU
// bus and up to 8 memory-mapped slaves. Each capture registers the address,
// write data and a one-hot slave select. A per-slave wait count holds the
// CPU off (cpu_rdy low) before the access completes.
// Optional macro BUS_ERR_EN adds a sticky capture of the first unmapped
// access address (err_flag / err_addr, cleared by err_clr).
module bus_decoder #(
  parameter int                  NSLV = 4,
  parameter int                  AW   = 16,
  parameter int                  DW   = 8,
  parameter logic [NSLV*AW-1:0]  BASE = {16'h0000, 16'h5000, 16'h6000, 16'h8000},
  parameter logic [NSLV*AW-1:0]  MASK = {16'hC000, 16'hF000, 16'hF000, 16'h8000},
  parameter logic [NSLV*2-1:0]   WAIT = {2'd0, 2'd2, 2'd1, 2'd0}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      cpu_ad,
  input  logic               cpu_we,
  input  logic [DW-1:0]      cpu_do,
  output logic [DW-1:0]      cpu_di,
  output logic               cpu_rdy,
  output logic [AW-1:0]      slv_addr,
  output logic [NSLV-1:0]    slv_cs,
  output logic               slv_we,
  output logic [DW-1:0]      slv_wdata,
  input  logic [NSLV*DW-1:0] slv_rdata,
  input  logic               err_clr,
  output logic               err_flag,
  output logic [AW-1:0]      err_addr
);

  typedef enum logic {S_ACT, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic [1:0]      cnt, cnt_nxt;
  logic [1:0]      wait_ld;
  logic            capture;
  logic            wr_q;
  logic [NSLV-1:0] match, hit;
  logic [DW-1:0]   rd_mux;

  // Per-slave address compare.
  genvar g;
  generate
    for (g = 0; g < NSLV; g++) begin : g_match
      assign match[g] = (cpu_ad & MASK[g*AW +: AW]) == BASE[g*AW +: AW];
    end
  endgenerate

  // Lowest index wins: isolate the least significant set bit.
  assign hit = match & (~match + NSLV'(1));

  // Wait count for the hit slave; zero when unmapped (hit is one-hot or zero).
  always_comb begin
    wait_ld = '0;
    for (int i = 0; i < NSLV; i++)
      if (hit[i]) wait_ld = wait_ld | WAIT[i*2 +: 2];
  end

  // Next-state: ACT captures every cycle, WAIT counts down and holds the bus.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      S_ACT: begin
        capture = 1'b1;
        cnt_nxt = wait_ld;
        if (wait_ld != 2'd0) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = cnt - 2'd1;
        if (cnt == 2'd1) state_nxt = S_ACT;
      end
      default: begin
        state_nxt = S_ACT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ACT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Address/data/select capture; held while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      slv_addr  <= '0;
      slv_cs    <= '0;
      wr_q      <= 1'b0;
      slv_wdata <= '0;
    end else if (capture) begin
      slv_addr  <= cpu_ad;
      slv_cs    <= hit;
      wr_q      <= cpu_we;
      slv_wdata <= cpu_do;
    end
  end

  // Read-data mux on the registered select; all-ones when nothing is selected.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NSLV; i++)
      if (slv_cs[i]) rd_mux = rd_mux | slv_rdata[i*DW +: DW];
  end

  // Combinational outputs are forced to their idle values while rst is high,
  // so a reset raised mid-wait can never let a write strobe escape.
  assign cpu_di  = (rst || slv_cs == '0) ? {DW{1'b1}} : rd_mux;
  assign cpu_rdy = rst || (cnt == 2'd0);
  assign slv_we  = !rst && wr_q && (cnt == 2'd0) && (slv_cs != '0);

`ifdef BUS_ERR_EN
  logic err_set;
  // A clear coinciding with an unmapped capture lets the new capture latch.
  assign err_set = capture && (hit == '0) && (!err_flag || err_clr);

  // Sticky first-unmapped-access capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (err_set) begin
      err_flag <= 1'b1;
      err_addr <= cpu_ad;
    end else if (err_clr) begin
      err_flag <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_flag       = 1'b0;
  assign err_addr       = '0;
`endif

endmodule

// File: tb/tb_bus_decoder.sv
// tb_bus_decoder: table-driven check of bus_decoder with default parameters,
// plus hand-written sequences for the wait-state strobe and mid-wait reset.
module tb_bus_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_ad;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic [15:0] slv_addr;
  logic [3:0]  slv_cs;
  logic        slv_we;
  logic [7:0]  slv_wdata;
  logic [31:0] slv_rdata;
  logic        err_clr;
  logic        err_flag;
  logic [15:0] err_addr;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  bus_decoder dut (
    .clk(clk), .rst(rst), .cpu_ad(cpu_ad), .cpu_we(cpu_we), .cpu_do(cpu_do),
    .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .slv_addr(slv_addr), .slv_cs(slv_cs),
    .slv_we(slv_we), .slv_wdata(slv_wdata), .slv_rdata(slv_rdata),
    .err_clr(err_clr), .err_flag(err_flag), .err_addr(err_addr)
  );

  typedef struct {
    logic        rst;
    logic [15:0] ad;
    logic        we;
    logic [7:0]  wd;
    logic        clr;
    logic        rdy;
    logic [3:0]  cs;
    logic        swe;
    logic [7:0]  di;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ef;
    logic [15:0] ea;
  } vec_t;

  vec_t tv[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [15:0] a, input logic w,
                       input logic [7:0] d, input logic c);
    rst = r; cpu_ad = a; cpu_we = w; cpu_do = d; err_clr = c;
  endtask

  initial begin
    logic [54:0] act, exp;
    logic        ef_e;
    logic [15:0] ea_e;
    int          lows, wes;

    // slave0 A5, slave1 11, slave2 22, slave3 33
    slv_rdata = {8'h33, 8'h22, 8'h11, 8'hA5};

    //        rst ad        we wd     clr | rdy cs       swe di     addr      wdata  ef ea
    tv[0]  = '{1, 16'h1234, 1, 8'h55, 0,    1, 4'b0000, 0, 8'hFF, 16'h0000, 8'h00, 0, 16'h0000};
    tv[1]  = '{1, 16'h9234, 0, 8'h00, 0,    1, 4'b0000, 0, 8'hFF, 16'h0000, 8'h00, 0, 16'h0000};
    tv[2]  = '{0, 16'h9234, 0, 8'h00, 0,    1, 4'b0001, 0, 8'hA5, 16'h9234, 8'h00, 0, 16'h0000};
    tv[3]  = '{0, 16'h0010, 0, 8'h00, 0,    1, 4'b1000, 0, 8'h33, 16'h0010, 8'h00, 0, 16'h0000};
    tv[4]  = '{0, 16'h8000, 0, 8'h00, 0,    1, 4'b0001, 0, 8'hA5, 16'h8000, 8'h00, 0, 16'h0000};
    tv[5]  = '{0, 16'h0011, 0, 8'h00, 0,    1, 4'b1000, 0, 8'h33, 16'h0011, 8'h00, 0, 16'h0000};
    tv[6]  = '{0, 16'h5001, 1, 8'h3C, 0,    0, 4'b0100, 0, 8'h22, 16'h5001, 8'h3C, 0, 16'h0000};
    tv[7]  = '{0, 16'h8000, 0, 8'h99, 0,    0, 4'b0100, 0, 8'h22, 16'h5001, 8'h3C, 0, 16'h0000};
    tv[8]  = '{0, 16'h0000, 1, 8'h77, 0,    1, 4'b0100, 1, 8'h22, 16'h5001, 8'h3C, 0, 16'h0000};
    tv[9]  = '{0, 16'h9000, 0, 8'h00, 0,    1, 4'b0001, 0, 8'hA5, 16'h9000, 8'h00, 0, 16'h0000};
    tv[10] = '{0, 16'h0020, 1, 8'h5A, 0,    1, 4'b1000, 1, 8'h33, 16'h0020, 8'h5A, 0, 16'h0000};
    tv[11] = '{0, 16'h4000, 0, 8'h00, 0,    1, 4'b0000, 0, 8'hFF, 16'h4000, 8'h00, 1, 16'h4000};
    tv[12] = '{0, 16'h7000, 0, 8'h00, 0,    1, 4'b0000, 0, 8'hFF, 16'h7000, 8'h00, 1, 16'h4000};
    tv[13] = '{0, 16'h4123, 1, 8'hAB, 0,    1, 4'b0000, 0, 8'hFF, 16'h4123, 8'hAB, 1, 16'h4000};
    tv[14] = '{0, 16'h7FFF, 1, 8'hCD, 1,    1, 4'b0000, 0, 8'hFF, 16'h7FFF, 8'hCD, 1, 16'h7FFF};
    tv[15] = '{0, 16'h8000, 0, 8'h00, 1,    1, 4'b0001, 0, 8'hA5, 16'h8000, 8'h00, 0, 16'h7FFF};
    tv[16] = '{0, 16'h6002, 1, 8'hE1, 0,    0, 4'b0010, 0, 8'h11, 16'h6002, 8'hE1, 0, 16'h7FFF};
    tv[17] = '{1, 16'h6002, 1, 8'hE1, 0,    1, 4'b0000, 0, 8'hFF, 16'h0000, 8'h00, 0, 16'h0000};
    tv[18] = '{0, 16'h6002, 1, 8'hE1, 0,    0, 4'b0010, 0, 8'h11, 16'h6002, 8'hE1, 0, 16'h0000};
    tv[19] = '{0, 16'h6002, 1, 8'hE1, 0,    1, 4'b0010, 1, 8'h11, 16'h6002, 8'hE1, 0, 16'h0000};
    tv[20] = '{0, 16'h0000, 0, 8'h00, 0,    1, 4'b1000, 0, 8'h33, 16'h0000, 8'h00, 0, 16'h0000};

    for (int i = 0; i < 21; i++) begin
      drive(tv[i].rst, tv[i].ad, tv[i].we, tv[i].wd, tv[i].clr);
      @(posedge clk); #1;
`ifdef BUS_ERR_EN
      ef_e = tv[i].ef; ea_e = tv[i].ea;
`else
      ef_e = 1'b0; ea_e = 16'h0000;
`endif
      act = {cpu_rdy, slv_cs, slv_we, cpu_di, slv_addr, slv_wdata, err_flag, err_addr};
      exp = {tv[i].rdy, tv[i].cs, tv[i].swe, tv[i].di, tv[i].addr, tv[i].wdata, ef_e, ea_e};
      check($sformatf("vec%0d {rdy,cs,we,di,addr,wdata,ef,ea}", i), 64'(act), 64'(exp));
    end

    // Two-wait write: exactly two not-ready cycles and one strobe.
    lows = 0; wes = 0;
    drive(0, 16'h5001, 1, 8'h3C, 0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (!cpu_rdy) lows++;
      if (slv_we) begin
        wes++;
        check("seq_wait2_wdata", 64'(slv_wdata), 64'(8'h3C));
      end
      drive(0, 16'h9000, 0, 8'h00, 0);
    end
    check("seq_wait2_rdy_low_cycles", 64'(lows), 64'(2));
    check("seq_wait2_we_pulses", 64'(wes), 64'(1));

    // Reset raised mid-wait: idle outputs immediately, registers cleared next edge.
    drive(0, 16'h5002, 1, 8'h42, 0);
    @(posedge clk); #1;
    check("seq_midrst_waiting_rdy", 64'(cpu_rdy), 64'(0));
    rst = 1'b1; #1;
    check("seq_midrst_comb {rdy,we,di}", 64'({cpu_rdy, slv_we, cpu_di}), 64'({1'b1, 1'b0, 8'hFF}));
    @(posedge clk); #1;
    check("seq_midrst_regs {cs,addr,wdata}", 64'({slv_cs, slv_addr, slv_wdata}), 64'(0));
    drive(0, 16'h0030, 0, 8'h00, 0);
    @(posedge clk); #1;
    check("seq_midrst_resume {rdy,cs,we,di}", 64'({cpu_rdy, slv_cs, slv_we, cpu_di}),
          64'({1'b1, 4'b1000, 1'b0, 8'h33}));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 Parameter NSLV, default 4: number of slave regions, range 1..8.
REQ-002 Parameter AW, default 16: address width.
REQ-003 Parameter DW, default 8: data width.
REQ-004 Parameter BASE, default {16'h0000,16'h5000,16'h6000,16'h8000}: packed NSLV*AW vector; slave i base address at bits [i*AW +: AW].
REQ-005 Parameter MASK, default {16'hC000,16'hF000,16'hF000,16'h8000}: packed NSLV*AW vector of decode masks, same packing as BASE.
REQ-006 Parameter WAIT, default {2'd0,2'd2,2'd1,2'd0}: packed NSLV*2 vector; slave i wait states (0..3) at bits [i*2 +: 2].
REQ-007 clk  in  1  system clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 cpu_ad  in  AW  CPU address, valid each cycle.
REQ-010 cpu_we  in  1  CPU write enable, active high.
REQ-011 cpu_do  in  DW  CPU write data.
REQ-012 cpu_di  out  DW  read data returned to the CPU.
REQ-013 cpu_rdy  out  1  high = CPU may advance; low = CPU holds its bus.
REQ-014 slv_addr  out  AW  registered address to slaves.
REQ-015 slv_cs  out  NSLV  registered one-hot slave select.
REQ-016 slv_we  out  1  single-cycle write strobe.
REQ-017 slv_wdata  out  DW  registered write data.
REQ-018 slv_rdata  in  NSLV*DW  slave read data; slave i at bits [i*DW +: DW].
REQ-019 err_clr  in  1  clears error capture (BUS_ERR_EN only).
REQ-020 err_flag / err_addr  out  1 / AW  sticky unmapped-access flag and address (BUS_ERR_EN only).

Function
REQ-021 Slave i hits when (cpu_ad & MASK[i]) == BASE[i]; on multiple hits the lowest index wins; no hit = unmapped.
REQ-022 FSM states: ACT and WAIT; reset state is ACT.
REQ-023 In ACT, every cycle registers cpu_ad, cpu_we, cpu_do and the one-hot hit vector into slv_addr, the write flag, slv_wdata and slv_cs; it loads the wait counter with WAIT[hit], or 0 when unmapped.
REQ-024 Data phase is the cycle after capture; cpu_di = slv_rdata of the selected slave, or {DW{1'b1}} when slv_cs is zero; the mux is combinational on slv_cs.
REQ-025 The FSM enters WAIT when the loaded count is nonzero and decrements once per cycle; cpu_rdy = (count == 0), combinational.
REQ-026 In WAIT, slv_addr, slv_cs, slv_wdata and the write flag hold and cpu_ad is ignored; the FSM returns to ACT when count reaches 0.
REQ-027 slv_we = write flag AND (count == 0) AND any slv_cs bit, so it is high for exactly one cycle per write access.
REQ-028 A write to an unmapped address produces no slv_we and no slv_cs.
REQ-029 Back-to-back zero-wait accesses sustain one access per cycle with no idle cycle.

Reset
REQ-030 While rst is high: slv_addr = 0, slv_cs = 0, write flag = 0, slv_wdata = 0, count = 0, state = ACT, cpu_rdy = 1, slv_we = 0, cpu_di = all-ones, err_flag = 0, err_addr = 0.
REQ-031 A reset during WAIT abandons the access; no slv_we is issued for it.
REQ-032 Capture resumes in the first cycle after rst deasserts.

Configuration
REQ-033 With macro BUS_ERR_EN defined, the first unmapped capture while err_flag = 0 sets err_flag and latches its address into err_addr; later unmapped accesses do not overwrite err_addr.
REQ-034 With BUS_ERR_EN defined, err_clr clears err_flag; if err_clr coincides with a new unmapped capture, the new capture wins (set has priority).
REQ-035 Without BUS_ERR_EN, err_flag and err_addr are tied to 0, err_clr is ignored, and no error registers are synthesised.

Verification
REQ-036 Read at cpu_ad = 16'h9234 with slave 0 rdata = 8'hA5 -> next cycle slv_cs = 4'b0001, cpu_di = 8'hA5, cpu_rdy stays 1.
REQ-037 Write 8'h3C to 16'h5001 -> cpu_rdy low for 2 cycles, slv_cs = 4'b0100 held, slv_we high only in the 3rd cycle, slv_wdata = 8'h3C.
REQ-038 Read at 16'h4000 (unmapped) -> slv_cs = 0, cpu_di = 8'hFF, cpu_rdy = 1; with BUS_ERR_EN: err_flag = 1, err_addr = 16'h4000; a following read at 16'h7000 leaves err_addr = 16'h4000.
REQ-039 Write to 16'h6002, rst asserted in the first WAIT cycle -> no slv_we pulse; all outputs at reset values next cycle.
REQ-040 Consecutive reads 16'h0010, 16'h8000, 16'h0011 -> slv_cs = 0b1000, 0b0001, 0b1000 on successive cycles, cpu_rdy constantly 1.
REQ-041 err_clr pulsed in the same cycle as an unmapped write to 16'h7FFF -> err_flag remains 1, err_addr = 16'h7FFF.
